config_shift_sequencer: RTL and testbench

- Sequences the on-chip configuration shift register (SuperpixSel/Reset_not/ConfigIn/ConfigClk/ConfigLoad/ConfigOut chain) from the FPGA side.
- Host writes the full CONFIG_REG_WIDTH-bit pattern word-by-word into a TX buffer through the AXI register file, then issues start.
- The block generates ConfigClk, shifts the pattern LSB-first, captures ConfigOut into an RX buffer, pulses ConfigLoad, and reports done.
- Sits between the axi4lite register decode and the chip pins.

---
 rtl/cfg_seq_pkg.sv | 9 +
 rtl/cfg_clk_tick_gen.sv | 17 +
 rtl/config_shift_sequencer.sv | 139 +++++++++++++
 tb/tb_config_shift_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cfg_seq_pkg.sv
// cfg_seq_pkg: state type, load length and buffer sizing helper shared by the
// configuration shift sequencer files.
package cfg_seq_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, LOAD, DONE} cfg_seq_state_e;
   localparam int LOAD_TICKS = 2;
   function automatic int n_words(input int width, input int dw);
      return (width + dw - 1) / dw;
   endfunction
endpackage

// File: rtl/cfg_clk_tick_gen.sv
// cfg_clk_tick_gen: one-cycle tick every CLK_DIVIDER cycles while enabled;
// counter is held at zero while disabled so every sequence starts phase-aligned.
module cfg_clk_tick_gen #(
   parameter int CLK_DIVIDER = 100
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   output logic tick_o
);
   localparam int CW = $clog2(CLK_DIVIDER);
   logic [CW-1:0] cnt_q;
   assign tick_o = en_i && (cnt_q == CW'(CLK_DIVIDER - 1));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= (!en_i || tick_o) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/config_shift_sequencer.sv
// config_shift_sequencer: shifts a TX buffer LSB-first into the chip config chain,
// optionally capturing ConfigOut into an RX buffer (macro CFG_RX_CAPTURE_EN).
module config_shift_sequencer
   import cfg_seq_pkg::*;
#(
   parameter  int C_S_AXI_DATA_WIDTH = 32,
   parameter  int CONFIG_REG_WIDTH   = 5164,
   parameter  int CLK_DIVIDER        = 100,
   localparam int N_WORDS = n_words(CONFIG_REG_WIDTH, C_S_AXI_DATA_WIDTH),
   localparam int WADDR_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESETN,
   input  logic                          wr_en,
   input  logic [WADDR_W-1:0]            wr_addr,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data,
   input  logic                          rd_en,
   input  logic [WADDR_W-1:0]            rd_addr,
   output logic [C_S_AXI_DATA_WIDTH-1:0] rd_data,
   input  logic                          start,
   input  logic                          abort,
   input  logic                          chip_rst_req,
   input  logic                          sp_sel_req,
   output logic                          busy,
   output logic                          done,
   output logic                          aborted,
   output logic                          wr_err,
   output logic                          SuperpixSel,
   output logic                          Reset_not,
   output logic                          ConfigClk,
   output logic                          ConfigIn,
   output logic                          ConfigLoad,
   input  logic                          ConfigOut
);
   localparam int DW  = C_S_AXI_DATA_WIDTH;
   localparam int IW  = $clog2(CONFIG_REG_WIDTH);
   localparam int BW  = $clog2(DW);
   localparam int LCW = (LOAD_TICKS > 1) ? $clog2(LOAD_TICKS) : 1;
   cfg_seq_state_e    state_q;
   logic [IW-1:0]     bit_idx_q, sel_idx;
   logic [LCW-1:0]    load_cnt_q;
   logic [WADDR_W-1:0] sel_w;
   logic [BW-1:0]     sel_b;
   logic [DW-1:0]     tx_mem [N_WORDS];
   logic [DW-1:0]     rd_word;
   logic              tick, tx_sel_bit, kill;
   cfg_clk_tick_gen #(.CLK_DIVIDER(CLK_DIVIDER)) u_tick (
      .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .en_i(state_q != IDLE), .tick_o(tick)
   );
   // From IDLE the first bit is loaded; in SHIFT the bit after the current one.
   assign sel_idx    = (state_q == IDLE) ? '0 : bit_idx_q + 1'b1;
   assign sel_w      = WADDR_W'(int'(sel_idx) / DW);
   assign sel_b      = BW'(int'(sel_idx) % DW);
   assign tx_sel_bit = tx_mem[sel_w][sel_b];
   assign kill       = busy && (abort || chip_rst_req);
   always_ff @(posedge S_AXI_ACLK)
      if (wr_en && !busy) tx_mem[wr_addr] <= wr_data;
`ifdef CFG_RX_CAPTURE_EN
   localparam int REM = CONFIG_REG_WIDTH % DW;
   localparam logic [DW-1:0] LAST_MASK = (REM == 0) ? '1 : ({DW{1'b1}} >> (DW - REM));
   logic [1:0]         sync_q;
   logic [DW-1:0]      rx_mem [N_WORDS];
   logic [WADDR_W-1:0] cur_w;
   logic [BW-1:0]      cur_b;
   assign cur_w = WADDR_W'(int'(bit_idx_q) / DW);
   assign cur_b = BW'(int'(bit_idx_q) % DW);
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
      if (!S_AXI_ARESETN) sync_q <= '0;
      else sync_q <= {sync_q[0], ConfigOut};
   always_ff @(posedge S_AXI_ACLK)
      if (state_q == SHIFT && tick && !ConfigClk && !kill) rx_mem[cur_w][cur_b] <= sync_q[1];
   assign rd_word = rx_mem[rd_addr] & ((rd_addr == WADDR_W'(N_WORDS - 1)) ? LAST_MASK : '1);
`else
   logic unused_config_out;
   assign unused_config_out = ConfigOut;
   assign rd_word = tx_mem[rd_addr];
`endif
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
      if (!S_AXI_ARESETN) rd_data <= '0;
      else if (rd_en) rd_data <= rd_word;
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
      if (!S_AXI_ARESETN) begin
         state_q     <= IDLE;
         bit_idx_q   <= '0;
         load_cnt_q  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
         wr_err      <= 1'b0;
         SuperpixSel <= 1'b0;
         Reset_not   <= 1'b0;
         ConfigClk   <= 1'b0;
         ConfigIn    <= 1'b0;
         ConfigLoad  <= 1'b0;
      end else begin
         SuperpixSel <= sp_sel_req;
         Reset_not   <= ~chip_rst_req;
         done        <= 1'b0;
         if (wr_en && busy) wr_err <= 1'b1;
         if (kill) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            ConfigClk  <= 1'b0;
            ConfigLoad <= 1'b0;
            aborted    <= 1'b1;
         end else begin
            case (state_q)
               IDLE: if (start && !chip_rst_req) begin
                  state_q    <= SHIFT;
                  busy       <= 1'b1;
                  bit_idx_q  <= '0;
                  load_cnt_q <= '0;
                  ConfigIn   <= tx_sel_bit;
                  aborted    <= 1'b0;
                  wr_err     <= 1'b0;
               end
               SHIFT: if (tick) begin
                  ConfigClk <= ~ConfigClk;
                  if (ConfigClk && bit_idx_q == IW'(CONFIG_REG_WIDTH - 1)) begin
                     state_q    <= LOAD;
                     ConfigLoad <= 1'b1;
                  end else if (ConfigClk) begin
                     bit_idx_q <= sel_idx;
                     ConfigIn  <= tx_sel_bit;
                  end
               end
               LOAD: if (tick) begin
                  if (load_cnt_q == LCW'(LOAD_TICKS - 1)) begin
                     state_q    <= DONE;
                     ConfigLoad <= 1'b0;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                  end else load_cnt_q <= load_cnt_q + 1'b1;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
endmodule

// File: tb/tb_config_shift_sequencer.sv
// tb_config_shift_sequencer: directed run of the shift sequencer against a model
// chip register, with scoreboards for ConfigIn bits and buffer reads.
module tb_config_shift_sequencer;
   localparam int W = 40, D = 4, DW = 32;
   logic clk = 1'b0, rst_n = 1'b1;
   logic wr_en = 0, rd_en = 0, start = 0, abort = 0, chip_rst_req = 0, sp_sel_req = 0;
   logic [0:0] wr_addr = '0, rd_addr = '0;
   logic [DW-1:0] wr_data = '0, rd_data;
   logic busy, done, aborted, wr_err, SuperpixSel, Reset_not, ConfigClk, ConfigIn, ConfigLoad, ConfigOut;
   logic [W-1:0] tx_pat, pre_pat, chip_q;
   logic chip_preload = 1'b0;
   logic bit_q[$];
   logic [DW-1:0] rd_q[$];
   logic rd_pend = 1'b0;
   logic [DW-1:0] exp_rd0, exp_rd1;
   int total = 0, bad = 0;
   int k, done_at, loads, busy_at_done;
   always #5 clk = ~clk;
   config_shift_sequencer #(.C_S_AXI_DATA_WIDTH(DW), .CONFIG_REG_WIDTH(W), .CLK_DIVIDER(D)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .start(start), .abort(abort),
      .chip_rst_req(chip_rst_req), .sp_sel_req(sp_sel_req), .busy(busy), .done(done),
      .aborted(aborted), .wr_err(wr_err), .SuperpixSel(SuperpixSel), .Reset_not(Reset_not),
      .ConfigClk(ConfigClk), .ConfigIn(ConfigIn), .ConfigLoad(ConfigLoad), .ConfigOut(ConfigOut)
   );
   // Chip shift register: shifts toward bit 0 on rising ConfigClk, bit 0 drives ConfigOut.
   always @(posedge ConfigClk or posedge chip_preload)
      if (chip_preload) chip_q <= pre_pat;
      else chip_q <= {ConfigIn, chip_q[W-1:1]};
   assign ConfigOut = chip_q[0];
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   always @(posedge ConfigClk)
      if (bit_q.size() > 0) chk("config_in", 64'(ConfigIn), 64'(bit_q.pop_front()));
      else chk("config_clk_unexpected", 64'(bit_q.size()), 64'd1);
   always @(posedge clk) rd_pend <= rd_en;
   always @(negedge clk)
      if (rd_pend && rd_q.size() > 0) chk("rd_data", 64'(rd_data), 64'(rd_q.pop_front()));
   task automatic cyc();
      @(negedge clk);
      k++;
      if (done === 1'b1 && done_at < 0) begin
         done_at = k;
         busy_at_done = int'(busy);
      end
      if (ConfigLoad === 1'b1) loads++;
   endtask
   task automatic begin_run();
      @(negedge clk);
      start = 1'b1;
      k = 0;
      done_at = -1;
      loads = 0;
      busy_at_done = -1;
      cyc();
      start = 1'b0;
   endtask
   task automatic push_bits();
      bit_q.delete();
      for (int i = 0; i < W; i++) bit_q.push_back(tx_pat[i]);
   endtask
   task automatic preload();
      chip_preload = 1'b1;
      #1 chip_preload = 1'b0;
   endtask
   task automatic do_write(input logic [0:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask
   task automatic do_read(input logic [0:0] a, input logic [DW-1:0] e);
      @(negedge clk);
      rd_en = 1'b1; rd_addr = a;
      rd_q.push_back(e);
      @(negedge clk);
      rd_en = 1'b0;
      @(negedge clk);
   endtask
   initial begin
      #1_000_000;
      $error("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      tx_pat  = 40'hC3_A5A50F0F;
      pre_pat = 40'h12_3456789A;
`ifdef CFG_RX_CAPTURE_EN
      exp_rd0 = pre_pat[31:0];
      exp_rd1 = {24'h0, pre_pat[39:32]};
`else
      exp_rd0 = tx_pat[31:0];
      exp_rd1 = {24'h0, tx_pat[39:32]};
`endif
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_aborted", 64'(aborted), 0);
      chk("rst_wr_err", 64'(wr_err), 0);
      chk("rst_sp_sel", 64'(SuperpixSel), 0);
      chk("rst_reset_not", 64'(Reset_not), 0);
      chk("rst_cfg_clk", 64'(ConfigClk), 0);
      chk("rst_cfg_in", 64'(ConfigIn), 0);
      chk("rst_cfg_load", 64'(ConfigLoad), 0);
      chk("rst_rd_data", 64'(rd_data), 0);
      rst_n = 1'b1;
      sp_sel_req = 1'b1;
      @(negedge clk);
      chk("reset_not_follow", 64'(Reset_not), 1);
      chk("sp_sel_follow", 64'(SuperpixSel), 1);
      do_write(1'b0, tx_pat[31:0]);
      do_write(1'b1, {24'h0, tx_pat[39:32]});
      // Nominal run, with a dropped write and an ignored start while shifting.
      preload();
      push_bits();
      begin_run();
      chk("busy_after_start", 64'(busy), 1);
      while (done_at < 0 && k < 2000) begin
         cyc();
         if (k == 50) begin wr_en = 1'b1; wr_addr = 1'b0; wr_data = '1; end
         if (k == 51) wr_en = 1'b0;
         if (k == 52) chk("wr_err_set", 64'(wr_err), 1);
         if (k == 60) start = 1'b1;
         if (k == 61) start = 1'b0;
      end
      chk("done_cycle", 64'(done_at), 64'(2 * W + 2) * D + 1);
      chk("busy_at_done", 64'(busy_at_done), 0);
      chk("load_cycles", 64'(loads), 64'(2 * D));
      chk("bits_left", 64'(bit_q.size()), 0);
      chk("chip_loaded", 64'(chip_q), 64'(tx_pat));
      cyc();
      chk("done_pulse", 64'(done), 0);
      chk("wr_err_sticky", 64'(wr_err), 1);
      do_read(1'b0, exp_rd0);
      do_read(1'b1, exp_rd1);
      // Abort mid-shift, then a clean rerun clears aborted.
      preload();
      push_bits();
      begin_run();
      chk("wr_err_cleared", 64'(wr_err), 0);
      while (k < 500) begin
         cyc();
         if (k == 100) abort = 1'b1;
         if (k == 101) begin
            abort = 1'b0;
            chk("abort_idle", 64'(busy), 0);
            chk("abort_clk", 64'(ConfigClk), 0);
            chk("abort_flag", 64'(aborted), 1);
         end
      end
      chk("abort_no_done", 64'(done_at), 64'(-1));
      chk("abort_no_load", 64'(loads), 0);
      preload();
      push_bits();
      begin_run();
      chk("aborted_cleared", 64'(aborted), 0);
      while (done_at < 0 && k < 2000) cyc();
      chk("rerun_done_cycle", 64'(done_at), 64'(2 * W + 2) * D + 1);
      chk("rerun_chip_loaded", 64'(chip_q), 64'(tx_pat));
      // Start is refused while the chip is held in reset.
      chip_rst_req = 1'b1;
      @(negedge clk);
      chk("reset_not_low", 64'(Reset_not), 0);
      begin_run();
      cyc();
      chk("rst_req_start_ignored", 64'(busy), 0);
      chip_rst_req = 1'b0;
      cyc();
      // Raising chip_rst_req mid-shift aborts.
      push_bits();
      begin_run();
      while (k < 51) begin
         cyc();
         if (k == 50) chip_rst_req = 1'b1;
      end
      chk("rst_req_aborted", 64'(aborted), 1);
      chk("rst_req_reset_not", 64'(Reset_not), 0);
      chk("rst_req_idle", 64'(busy), 0);
      chip_rst_req = 1'b0;
      bit_q.delete();
      cyc();
      // Asynchronous reset during LOAD.
      preload();
      push_bits();
      begin_run();
      while (ConfigLoad !== 1'b1 && k < 2000) cyc();
      chk("reached_load", 64'(ConfigLoad), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_load", 64'(ConfigLoad), 0);
      chk("async_clk", 64'(ConfigClk), 0);
      chk("async_busy", 64'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      do_read(1'b0, exp_rd0);
      do_read(1'b1, exp_rd1);
      chk("rd_queue_empty", 64'(rd_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
